set_time: RTL and testbench

Real-time calendar clock with push-button time setting for the clock display board. Keeps year/month/day/hour/minute/second/weekday in BCD, advanced by a 1 Hz tick derived from the system clock. When `mode` selects set mode the clock pauses and five buttons move a field cursor and edit the selected field. Outputs feed the display and alarm blocks directly.

---
 rtl/set_time_pkg.sv | 42 ++++
 rtl/set_time_bcd.sv | 54 +++++
 rtl/set_time.sv | 168 ++++++++++++++++
 tb/tb_set_time.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_time_pkg.sv
// Shared constants and calendar helpers for the set_time calendar clock.
//   SET_MODE_DEFAULT : mode value that enables editing
//   F_YEAR..F_WEEK   : cursor field indices
//   B_MID..B_DOWN    : bit positions in the packed button vector
//   days_in_month()  : BCD days in a month for years 2000-2099
package set_time_pkg;

    localparam int unsigned CUR_W = 3;
    localparam int unsigned BTN_W = 5;
    localparam int unsigned NUM_FIELDS = 7;

    localparam logic [3:0] SET_MODE_DEFAULT = 4'h1;

    localparam logic [CUR_W-1:0] F_YEAR  = 3'd0;
    localparam logic [CUR_W-1:0] F_MONTH = 3'd1;
    localparam logic [CUR_W-1:0] F_DAY   = 3'd2;
    localparam logic [CUR_W-1:0] F_HOUR  = 3'd3;
    localparam logic [CUR_W-1:0] F_MIN   = 3'd4;
    localparam logic [CUR_W-1:0] F_SEC   = 3'd5;
    localparam logic [CUR_W-1:0] F_WEEK  = 3'd6;

    localparam int unsigned B_MID  = 0;
    localparam int unsigned B_L    = 1;
    localparam int unsigned B_R    = 2;
    localparam int unsigned B_UP   = 3;
    localparam int unsigned B_DOWN = 4;

    // Year mod 4 is an exact leap rule inside 2000-2099.
    function automatic logic [7:0] days_in_month(input logic [7:0] month_bcd,
                                                 input logic [7:0] yy_bcd);
        logic [7:0] yy_bin;
        logic       leap;
        yy_bin = 8'(yy_bcd[7:4]) * 8'd10 + 8'(yy_bcd[3:0]);
        leap   = ((yy_bin % 8'd4) == 8'd0);
        case (month_bcd)
            8'h02:                      days_in_month = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: days_in_month = 8'h30;
            default:                    days_in_month = 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/set_time_bcd.sv
// Two-digit BCD register counting between min_val and max_val with wrap.
//   load/load_val : overriding parallel load
//   inc / dec     : step up / down (inc wins), wrapping max<->min
//   value         : registered BCD value
//   next_c        : value after this edge (combinational)
//   carry_c       : inc requested while at max (wrap up happening)
module bcd_counter #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    input  logic       dec,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    output logic [7:0] value,
    output logic [7:0] next_c,
    output logic       carry_c
);

    // Next-value selection; BCD compares numerically digit by digit.
    always_comb begin
        next_c  = value;
        carry_c = 1'b0;
        if (load) begin
            next_c = load_val;
        end else if (inc) begin
            if (value >= max_val) begin
                next_c  = min_val;
                carry_c = 1'b1;
            end else if (value[3:0] == 4'd9) begin
                next_c = {value[7:4] + 4'd1, 4'd0};
            end else begin
                next_c = {value[7:4], value[3:0] + 4'd1};
            end
        end else if (dec) begin
            if (value <= min_val) begin
                next_c = max_val;
            end else if (value[3:0] == 4'd0) begin
                next_c = {value[7:4] - 4'd1, 4'd9};
            end else begin
                next_c = {value[7:4], value[3:0] - 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value <= RST_VAL;
        else        value <= next_c;
    end

endmodule

// File: rtl/set_time.sv
// BCD calendar clock with 1 Hz tick and push-button field editing.
//   clk, rst_n       : system clock, async active-low reset
//   button_*         : debounced levels; rising edges act in set mode only
//   mode             : editing enabled when equal to SET_MODE
//   year..sec, week  : registered BCD calendar outputs (week binary 1-7)
module set_time
    import set_time_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter logic [3:0]  SET_MODE = SET_MODE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        button_mid,
    input  logic        button_r,
    input  logic        button_l,
    input  logic        button_up,
    input  logic        button_down,
    input  logic [3:0]  mode,
    output logic [15:0] year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  sec,
    output logic [3:0]  week
);

    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

    logic [BTN_W-1:0] btn_raw, sync1, sync2, btn_prev, rise_c;
    logic             set_c, tick_c;
    logic             act_mid, act_l, act_r, act_up, act_dn;
    logic [CUR_W-1:0] cursor;
    logic [PRE_W-1:0] presc;
    logic [NUM_FIELDS-1:0] sel_c, up_c, dn_c;

    assign btn_raw = {button_down, button_up, button_r, button_l, button_mid};

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            btn_prev <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            btn_prev <= sync2;
        end
    end

    assign rise_c = sync2 & ~btn_prev;
    assign set_c  = (mode == SET_MODE);

    // Only the highest-priority edge acts: mid > l > r > up > down.
    assign act_mid = set_c & rise_c[B_MID];
    assign act_l   = set_c & rise_c[B_L] & ~rise_c[B_MID];
    assign act_r   = set_c & rise_c[B_R] & ~rise_c[B_L] & ~rise_c[B_MID];
    assign act_up  = set_c & rise_c[B_UP] & ~rise_c[B_R] & ~rise_c[B_L] & ~rise_c[B_MID];
    assign act_dn  = set_c & rise_c[B_DOWN] & ~rise_c[B_UP] & ~rise_c[B_R]
                   & ~rise_c[B_L] & ~rise_c[B_MID];

    // Cursor parks at year outside set mode, so entry always starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cursor <= F_YEAR;
        else if (!set_c)  cursor <= F_YEAR;
        else if (act_l)   cursor <= (cursor == F_YEAR) ? F_WEEK : cursor - CUR_W'(1);
        else if (act_r)   cursor <= (cursor == F_WEEK) ? F_YEAR : cursor + CUR_W'(1);
    end

    // Seconds prescaler; held at 0 while editing so run resumes on a full period.
    assign tick_c = ~set_c & (presc == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          presc <= '0;
        else if (set_c || act_mid || tick_c) presc <= '0;
        else                                 presc <= presc + PRE_W'(1);
    end

    always_comb begin
        sel_c = '0;
        for (int i = 0; i < int'(NUM_FIELDS); i++) begin
            sel_c[i] = (cursor == CUR_W'(i));
        end
    end

    assign up_c = {NUM_FIELDS{act_up}} & sel_c;
    assign dn_c = {NUM_FIELDS{act_dn}} & sel_c;

    logic       sec_cy, min_cy, hour_cy, day_cy, mon_cy, ylo_cy, yhi_cy, week_cy;
    logic [7:0] sec_nx, min_nx, hour_nx, day_nx, mon_nx, ylo_nx, yhi_nx, week_nx;
    logic [7:0] week_bcd, dim_cur_c, dim_next_c;
    logic       day_clamp_c;

    // Edits also raise carry_c, so only tick-qualified carries ripple.
    logic c_sec, c_min, c_hour, c_day, c_mon, c_ylo;
    assign c_sec  = tick_c & sec_cy;
    assign c_min  = tick_c & min_cy;
    assign c_hour = tick_c & hour_cy;
    assign c_day  = tick_c & day_cy;
    assign c_mon  = tick_c & mon_cy;
    assign c_ylo  = tick_c & ylo_cy;

    // Day limit for running, and for clamping against the post-edit month/year.
    assign dim_cur_c   = days_in_month(month, year[7:0]);
    assign dim_next_c  = days_in_month(mon_nx, ylo_nx);
    assign day_clamp_c = (up_c[F_YEAR] | dn_c[F_YEAR] | up_c[F_MONTH] | dn_c[F_MONTH])
                       & (day > dim_next_c);

    bcd_counter #(.RST_VAL(8'h00)) u_sec (
        .clk(clk), .rst_n(rst_n), .load(act_mid), .load_val(8'h00),
        .inc(tick_c | up_c[F_SEC]), .dec(dn_c[F_SEC]),
        .min_val(8'h00), .max_val(8'h59),
        .value(sec), .next_c(sec_nx), .carry_c(sec_cy));

    bcd_counter #(.RST_VAL(8'h00)) u_min (
        .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val(8'h00),
        .inc(c_sec | up_c[F_MIN]), .dec(dn_c[F_MIN]),
        .min_val(8'h00), .max_val(8'h59),
        .value(minute), .next_c(min_nx), .carry_c(min_cy));

    bcd_counter #(.RST_VAL(8'h00)) u_hour (
        .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val(8'h00),
        .inc(c_min | up_c[F_HOUR]), .dec(dn_c[F_HOUR]),
        .min_val(8'h00), .max_val(8'h23),
        .value(hour), .next_c(hour_nx), .carry_c(hour_cy));

    bcd_counter #(.RST_VAL(8'h01)) u_day (
        .clk(clk), .rst_n(rst_n), .load(day_clamp_c), .load_val(dim_next_c),
        .inc(c_hour | up_c[F_DAY]), .dec(dn_c[F_DAY]),
        .min_val(8'h01), .max_val(dim_cur_c),
        .value(day), .next_c(day_nx), .carry_c(day_cy));

    bcd_counter #(.RST_VAL(8'h01)) u_month (
        .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val(8'h00),
        .inc(c_day | up_c[F_MONTH]), .dec(dn_c[F_MONTH]),
        .min_val(8'h01), .max_val(8'h12),
        .value(month), .next_c(mon_nx), .carry_c(mon_cy));

    bcd_counter #(.RST_VAL(8'h00)) u_year_lo (
        .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val(8'h00),
        .inc(c_mon | up_c[F_YEAR]), .dec(dn_c[F_YEAR]),
        .min_val(8'h00), .max_val(8'h99),
        .value(year[7:0]), .next_c(ylo_nx), .carry_c(ylo_cy));

    // Century pinned at 20: a carry out of 99 wraps it back onto itself.
    bcd_counter #(.RST_VAL(8'h20)) u_year_hi (
        .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val(8'h00),
        .inc(c_ylo), .dec(1'b0),
        .min_val(8'h20), .max_val(8'h20),
        .value(year[15:8]), .next_c(yhi_nx), .carry_c(yhi_cy));

    // Weekday advances with every new day, 7 wraps to 1.
    bcd_counter #(.RST_VAL(8'h06)) u_week (
        .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val(8'h00),
        .inc(c_hour | up_c[F_WEEK]), .dec(dn_c[F_WEEK]),
        .min_val(8'h01), .max_val(8'h07),
        .value(week_bcd), .next_c(week_nx), .carry_c(week_cy));

    assign week = week_bcd[3:0];

    logic unused_c;
    assign unused_c = ^{sec_nx, min_nx, hour_nx, day_nx, yhi_nx, week_nx,
                        yhi_cy, week_cy, week_bcd[7:4]};

endmodule

// File: tb/tb_set_time.sv
// Randomized and directed bench for set_time against a calendar-level model.
module tb_set_time;

    localparam int HZ = 4;
    localparam int MID = 0, BL = 1, BR = 2, UP = 3, DN = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  btn;
    logic [3:0]  mode;
    logic [15:0] year;
    logic [7:0]  month, day, hour, minute, sec;
    logic [3:0]  week;

    set_time #(.CLK_HZ(HZ), .SET_MODE(4'h1)) dut (
        .clk(clk), .rst_n(rst_n),
        .button_mid(btn[MID]), .button_r(btn[BR]), .button_l(btn[BL]),
        .button_up(btn[UP]), .button_down(btn[DN]),
        .mode(mode),
        .year(year), .month(month), .day(day), .hour(hour),
        .minute(minute), .sec(sec), .week(week));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state: plain integers for the calendar
    int m_yr, m_mo, m_dy, m_hr, m_mi, m_se, m_wk, m_cur, m_pre;
    bit m_was_set;
    bit [4:0] p0, p1, p2, p3;

    function automatic int dim(input int y, input int m);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int wrap(input int v, input int lo, input int hi);
        int r;
        r = hi - lo + 1;
        return lo + (((v - lo) % r) + r) % r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_yr = 2000; m_mo = 1; m_dy = 1; m_hr = 0; m_mi = 0; m_se = 0; m_wk = 6;
        m_cur = 0; m_pre = 0; m_was_set = 1'b0;
        p0 = '0; p1 = '0; p2 = '0; p3 = '0;
    endtask

    task automatic advance_second();
        m_se++;
        if (m_se == 60) begin
            m_se = 0; m_mi++;
            if (m_mi == 60) begin
                m_mi = 0; m_hr++;
                if (m_hr == 24) begin
                    m_hr = 0;
                    m_wk = m_wk % 7 + 1;
                    m_dy++;
                    if (m_dy > dim(m_yr, m_mo)) begin
                        m_dy = 1; m_mo++;
                        if (m_mo == 13) begin
                            m_mo = 1; m_yr++;
                            if (m_yr == 2100) m_yr = 2000;
                        end
                    end
                end
            end
        end
    endtask

    task automatic edit(input int d);
        case (m_cur)
            0: m_yr = wrap(m_yr + d, 2000, 2099);
            1: m_mo = wrap(m_mo + d, 1, 12);
            2: m_dy = wrap(m_dy + d, 1, dim(m_yr, m_mo));
            3: m_hr = wrap(m_hr + d, 0, 23);
            4: m_mi = wrap(m_mi + d, 0, 59);
            5: m_se = wrap(m_se + d, 0, 59);
            default: m_wk = wrap(m_wk + d, 1, 7);
        endcase
        if (m_cur <= 1 && m_dy > dim(m_yr, m_mo)) m_dy = dim(m_yr, m_mo);
    endtask

    // One clock edge of the calendar: buttons act three edges after they rise.
    task automatic model_step();
        bit [4:0] e;
        bit       set;
        p3 = p2; p2 = p1; p1 = p0; p0 = btn;
        e   = p2 & ~p3;
        set = (mode == 4'h1);
        if (set) begin
            if (!m_was_set) m_cur = 0;
            m_pre = 0;
            if (e[MID])      m_se = 0;
            else if (e[BL])  m_cur = (m_cur + 6) % 7;
            else if (e[BR])  m_cur = (m_cur + 1) % 7;
            else if (e[UP])  edit(1);
            else if (e[DN])  edit(-1);
        end else if (m_pre == HZ - 1) begin
            m_pre = 0;
            advance_second();
        end else begin
            m_pre++;
        end
        m_was_set = set;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) model_step();
            else       model_reset();
            #1;
        end
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        cyc(1);
        btn[idx] = 1'b0;
        cyc(4);
    endtask

    task automatic do_reset();
        btn   = '0;
        rst_n = 1'b0;
        model_reset();
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_literal(input string tag);
        check({tag, "_year"}, year, 16'h2000);
        check({tag, "_month"}, {8'h0, month}, 16'h0001);
        check({tag, "_day"}, {8'h0, day}, 16'h0001);
        check({tag, "_time"}, {hour, minute}, 16'h0000);
        check({tag, "_sec"}, {8'h0, sec}, 16'h0000);
        check({tag, "_week"}, {12'h0, week}, 16'h0006);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("year",   year, {8'h20, bcd2(m_yr - 2000)});
            check("month",  {8'h0, month},  {8'h0, bcd2(m_mo)});
            check("day",    {8'h0, day},    {8'h0, bcd2(m_dy)});
            check("hour",   {8'h0, hour},   {8'h0, bcd2(m_hr)});
            check("minute", {8'h0, minute}, {8'h0, bcd2(m_mi)});
            check("sec",    {8'h0, sec},    {8'h0, bcd2(m_se)});
            check("week",   {12'h0, week},  16'(m_wk));
        end
    end

    initial begin
        btn   = '0;
        mode  = 4'h0;
        rst_n = 1'b0;
        model_reset();
        cyc(2);
        chk_en = 1'b1;
        check_reset_literal("reset");
        rst_n = 1'b1;

        // First tick lands exactly CLK_HZ edges after reset release
        cyc(HZ - 1);
        check("pre_tick_sec", {8'h0, sec}, 16'h0000);
        cyc(1);
        check("first_tick_sec", {8'h0, sec}, 16'h0001);

        // 2000-12-31 23:59:59 Sunday -> 2001-01-01 00:00:00 Monday
        do_reset();
        mode = 4'h1;
        cyc(1);
        press(BR); press(DN);
        press(BR); press(DN);
        press(BR); press(DN);
        press(BR); press(DN);
        press(BR); press(DN);
        press(BR); press(UP);
        check("preset_date", {month, day}, 16'h1231);
        check("preset_week", {12'h0, week}, 16'h0007);
        mode = 4'h0;
        cyc(HZ);
        check("newyear_year", year, 16'h2001);
        check("newyear_date", {month, day}, 16'h0101);
        check("newyear_hms", {hour, minute}, 16'h0000);
        check("newyear_week", {12'h0, week}, 16'h0001);

        // Leap February 2000
        do_reset();
        mode = 4'h1;
        cyc(1);
        press(BR); press(UP);
        press(BR); press(DN); press(DN);
        press(BR); press(DN);
        press(BR); press(DN);
        press(BR); press(DN);
        mode = 4'h0;
        cyc(HZ);
        check("leap_date", {month, day}, 16'h0229);
        check("leap_hour", {8'h0, hour}, 16'h0000);

        // Non-leap February 2001
        do_reset();
        mode = 4'h1;
        cyc(1);
        press(UP);
        press(BR); press(UP);
        press(BR); press(DN);
        press(BR); press(DN);
        press(BR); press(DN);
        press(BR); press(DN);
        mode = 4'h0;
        cyc(HZ);
        check("nonleap_year", year, 16'h2001);
        check("nonleap_date", {month, day}, 16'h0301);

        // Cursor wraps left onto sec; sec wraps without touching minute
        do_reset();
        mode = 4'h1;
        cyc(1);
        press(BL); press(BL);
        press(DN);
        check("sec_down_wrap", {8'h0, sec}, 16'h0059);
        press(UP);
        check("sec_up_wrap", {8'h0, sec}, 16'h0000);
        check("min_untouched", {8'h0, minute}, 16'h0000);

        // 2000-03-31, month down clamps to Feb 29
        do_reset();
        mode = 4'h1;
        cyc(1);
        press(BR); press(UP); press(UP);
        press(BR); press(DN);
        press(BL); press(DN);
        check("clamp_date", {month, day}, 16'h0229);

        // Held button acts once; up beats down
        btn[UP] = 1'b1;
        cyc(100);
        btn[UP] = 1'b0;
        cyc(4);
        check("held_once", {8'h0, month}, 16'h0003);
        btn[UP] = 1'b1; btn[DN] = 1'b1;
        cyc(1);
        btn = '0;
        cyc(4);
        check("up_over_down", {8'h0, month}, 16'h0004);

        // Buttons ignored in run mode
        mode = 4'h0;
        cyc(1);
        press(UP); press(DN); press(BR); press(BL); press(MID);
        check("run_ignore", {month, day}, 16'h0429);

        // Asynchronous reset in the middle of an edit
        mode = 4'h1;
        btn[UP] = 1'b1;
        cyc(2);
        #3 rst_n = 1'b0;
        #1 check_reset_literal("async_rst");
        model_reset();
        btn = '0;
        cyc(2);
        rst_n = 1'b1;

        // Randomized segments of set/run mode with random button activity
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            if ($urandom_range(0, 9) < 6) mode = 4'h1;
            else                          mode = 4'($urandom_range(0, 15));
            for (int c = 0; c < int'($urandom_range(20, 80)); c++) begin
                for (int b = 0; b < 5; b++) btn[b] = ($urandom_range(0, 3) == 0);
                cyc(1);
            end
        end
        btn = '0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
